hilo_mult_sequencer: RTL

Multi-cycle multiply/accumulate unit that owns the architectural HI/LO register pair. It executes mult, multu, madd, msub, mthi and mtlo. The EX stage issues each operation through a start handshake. The unit runs an iterative 32-step shift-add multiply and raises a stall to the pipeline while busy, which replaces the single-cycle HI/LO path in the ALU. mfhi/mflo read the Hi/Lo outputs directly.

---
 rtl/hilo_mult_sequencer.sv | 78 +++++++
 1 files changed

// File: rtl/hilo_mult_sequencer.sv
// hilo_mult_sequencer: iterative 32-step shift-add multiply/accumulate unit owning the HI/LO pair.
module hilo_mult_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mf_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t      state;
  logic [63:0] mcand, prod, p, acc;
  logic [31:0] mplier, abs_a, abs_b;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic        neg, sgn;
  // Signed ops multiply magnitudes; 0x80000000 negates to itself, read unsigned as 2^31.
  always_comb begin
    sgn   = op[1:0] != 2'b01;
    abs_a = (sgn && a[31]) ? -a : a;
    abs_b = (sgn && b[31]) ? -b : b;
    p     = neg ? -prod : prod;
    acc   = op_q == 2'b10 ? {hi, lo} + p : op_q == 2'b11 ? {hi, lo} - p : p;
  end
  assign stall = busy & (start | mf_req);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      op_q   <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (!op[2]) begin
            mcand  <= {32'b0, abs_a};
            mplier <= abs_b;
            neg    <= sgn & (a[31] ^ b[31]);
            op_q   <= op[1:0];
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else if (op[1:0] == 2'b00) hi <= a;
          else if (op[1:0] == 2'b01) lo <= a;
        end
        RUN: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIN;
        end
        FIN: begin
          {hi, lo} <= acc;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
